imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries; legal values 2 to 8, powers of two.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts an instruction this cycle.
REQ-007 SHALL have port in_instr, input, 32, raw instruction word.
REQ-008 SHALL have port out_valid, output, 1, head entry valid.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes the head entry.
REQ-010 SHALL have port out_imm, output, XLEN, sign-extended immediate.
REQ-011 SHALL have port out_sel, output, 3, format code: 0 I, 1 B, 2 U, 3 S, 4 J, 5 none.
REQ-012 SHALL have port out_instr, output, 32, instruction word passed through with its immediate.

Function
REQ-013 SHALL decode opcode in_instr[6:0]: 19, 3, 103 -> I; 35 -> S; 99 -> B; 55, 23 -> U; 111 -> J; every other value -> none.
REQ-014 SHALL form immediates per RV32I: I = instr[31:20]; S = {instr[31:25], instr[11:7]}; B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U = {instr[31:12], 12'b0}; J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-015 SHALL sign-extend every immediate from instr[31] to XLEN; the none format SHALL give zero.
REQ-016 SHALL decode at input and write {imm, sel, instr} into a FIFO_DEPTH-entry circular buffer on a push, where push = in_valid && in_ready.
REQ-017 SHALL pop the head entry when out_valid && out_ready.
REQ-018 SHALL keep occupancy count 0..FIFO_DEPTH with states EMPTY (0), PARTIAL (1..DEPTH-1), and FULL (DEPTH); the state SHALL follow the count.
REQ-019 SHALL drive in_ready = !FULL from registered state only, with no combinational path from out_ready.
REQ-020 SHALL assert out_valid = !EMPTY and present the head entry.
REQ-021 SHALL give one cycle of latency: an instruction pushed into EMPTY is on the outputs in the next cycle.
REQ-022 SHALL hold out_imm, out_sel and out_instr stable while out_valid && !out_ready.
REQ-023 SHALL, on a push and pop in the same cycle, leave the count unchanged and advance both pointers.
REQ-024 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-025 SHALL ignore in_instr when in_valid is low and SHALL not pop when EMPTY.

Reset
REQ-026 SHALL, on rst_n low and at any time, immediately clear the count, both pointers and, if present, the error counter; in-flight entries are discarded.
REQ-027 SHALL, during reset, hold out_valid = 0, in_ready = 0, out_imm = 0, out_sel = 5 and out_instr = 0.
REQ-028 SHALL raise in_ready in the first clock edge after rst_n is released.

Configuration
REQ-029 SHALL, with macro IMM_GEN_ILLEGAL_COUNT_EN defined, add output illegal_cnt, 16 bits: it counts pushes whose format is none and saturates at 0xFFFF.
REQ-030 SHALL, without IMM_GEN_ILLEGAL_COUNT_EN, have no illegal_cnt port and no counter logic; all other behaviour is the same.

Structure
REQ-031 SHALL take the format-code constants (FMT_I..FMT_NONE) and the opcode constants from shared package imm_pkg.
REQ-032 SHALL put the decode and sign-extend logic in one combinational sub-module, imm_decode, with ports instr and sel/imm of width XLEN; the FIFO and state logic stay in imm_gen_pipe.

Verification
REQ-033 SHALL check: push 0xFFF00093 (addi, imm -1) at XLEN=64 -> next cycle out_sel=0, out_imm=0xFFFF_FFFF_FFFF_FFFF.
REQ-034 SHALL check: push 0x00112423 (sw, offset 8), then 0xFE000EE3 (beq, offset -4) -> out_sel 3 then 1, out_imm 8 then -4, in order.
REQ-035 SHALL check: hold out_ready=0 and push DEPTH instructions -> in_ready falls after the DEPTH-th push and the head stays stable; raise out_ready -> entries drain in order and in_ready rises one cycle after the first pop.
REQ-036 SHALL check: push and pop together with one entry held for 10 cycles -> count stays 1, the pointers wrap, and there is no loss or duplication.
REQ-037 SHALL check: assert rst_n low mid-stream with 2 entries held -> out_valid falls at once; after release, in_ready=1 and out_valid=0.
REQ-038 SHALL check: with IMM_GEN_ILLEGAL_COUNT_EN defined, push opcode 0x7F three times -> out_sel=5, out_imm=0, and illegal_cnt=3.

Source files
------------

// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared constants for the immediate generator: the format codes reported on
// out_sel, the RV32I major opcodes that select each format, and the occupancy
// states of the output buffer.
// No ports (package).
// -----------------------------------------------------------------------------
package imm_pkg;

   // Format codes presented on out_sel
   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_B    = 3'd1;
   localparam logic [2:0] FMT_U    = 3'd2;
   localparam logic [2:0] FMT_S    = 3'd3;
   localparam logic [2:0] FMT_J    = 3'd4;
   localparam logic [2:0] FMT_NONE = 3'd5;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_IMM    = 7'd19;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_LUI    = 7'd55;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_JAL    = 7'd111;

   // Output buffer occupancy
   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational RV32I immediate decoder. Classifies the instruction by
// opcode and builds the sign-extended immediate for that format.
// Parameters:
//   XLEN  - width of the produced immediate (32 or 64)
// Ports:
//   instr [31:0]     in   raw instruction word
//   sel   [2:0]      out  format code (FMT_I..FMT_NONE)
//   imm   [XLEN-1:0] out  sign-extended immediate, zero for FMT_NONE
// -----------------------------------------------------------------------------
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [2:0]      sel,
   output logic [XLEN-1:0] imm
);

   logic signed [31:0] imm32;

   // Widening a signed 32-bit value replicates bit 31 into the upper bits.
   function automatic logic [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   always_comb begin
      sel   = FMT_NONE;
      imm32 = '0;
      case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            sel   = FMT_I;
            imm32 = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            sel   = FMT_S;
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            sel   = FMT_B;
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            sel   = FMT_U;
            imm32 = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            sel   = FMT_J;
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: begin
            sel   = FMT_NONE;
            imm32 = '0;
         end
      endcase
      imm = sext_xlen(imm32);
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes the immediate of each accepted instruction and queues
// {imm, sel, instr} in a FIFO_DEPTH-entry circular buffer. One cycle of latency
// from an accepted instruction to the outputs when the buffer is empty.
// in_ready comes from registered state only (no path from out_ready).
// Optional feature: define IMM_GEN_ILLEGAL_COUNT_EN to add illegal_cnt, a
// saturating 16-bit count of accepted instructions with format none.
// Parameters:
//   XLEN       - immediate width (32 or 64)
//   FIFO_DEPTH - buffer entries (2..8, power of two)
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   in_valid           in   upstream instruction valid
//   in_ready           out  instruction accepted this cycle when in_valid
//   in_instr  [31:0]   in   raw instruction word
//   out_valid          out  head entry valid
//   out_ready          in   downstream consumes head entry
//   out_imm   [XLEN-1:0] out sign-extended immediate of head entry
//   out_sel   [2:0]    out  format code of head entry (5 when empty)
//   out_instr [31:0]   out  instruction word of head entry
//   illegal_cnt [15:0] out  (IMM_GEN_ILLEGAL_COUNT_EN only) format-none count
// -----------------------------------------------------------------------------
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_sel,
   output logic [31:0]     out_instr
`ifdef IMM_GEN_ILLEGAL_COUNT_EN
   ,
   output logic [15:0]     illegal_cnt
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   // ---- stage p0: decode of the incoming instruction ----
   logic [2:0]      dec_sel_p0;
   logic [XLEN-1:0] dec_imm_p0;

   imm_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .instr (in_instr),
      .sel   (dec_sel_p0),
      .imm   (dec_imm_p0)
   );

   // ---- stage p1: buffered entries and occupancy control ----
   logic [XLEN-1:0] imm_mem_p1   [FIFO_DEPTH];
   logic [2:0]      sel_mem_p1   [FIFO_DEPTH];
   logic [31:0]     instr_mem_p1 [FIFO_DEPTH];

   occ_e             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic             run_q;
   logic             vld_p1;
   logic             push, pop;

   // run_q keeps in_ready low while reset is asserted and lets it rise on the
   // first edge after release.
   assign vld_p1   = (state_q != OCC_EMPTY);
   assign in_ready = run_q && (state_q != OCC_FULL);
   assign push     = in_valid && in_ready;
   assign pop      = vld_p1 && out_ready;

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (cnt_d == '0) begin
         state_d = OCC_EMPTY;
      end else if (cnt_d == CNT_FULL) begin
         state_d = OCC_FULL;
      end else begin
         state_d = OCC_PARTIAL;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= OCC_EMPTY;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         run_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem_p1[wr_ptr_q]   <= dec_imm_p0;
         sel_mem_p1[wr_ptr_q]   <= dec_sel_p0;
         instr_mem_p1[wr_ptr_q] <= in_instr;
      end
   end

   // Storage is not reset, so the outputs are forced to their idle values
   // whenever no entry is valid (this also covers reset).
   assign out_valid = vld_p1;
   assign out_imm   = vld_p1 ? imm_mem_p1[rd_ptr_q]   : '0;
   assign out_sel   = vld_p1 ? sel_mem_p1[rd_ptr_q]   : FMT_NONE;
   assign out_instr = vld_p1 ? instr_mem_p1[rd_ptr_q] : '0;

`ifdef IMM_GEN_ILLEGAL_COUNT_EN
   logic [15:0] illegal_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= '0;
      end else if (push && (dec_sel_p0 == FMT_NONE)) begin
         illegal_q <= sat_inc16(illegal_q);
      end
   end

   assign illegal_cnt = illegal_q;
`endif

endmodule
